hwrandom_pool: RTL and testbench
================================

Name: hwrandom_pool

Overview:
Parametrised successor of the ring-oscillator entropy core. It takes the XOR-combined raw entropy bit and applies optional Von Neumann de-biasing. It assembles WORD_WIDTH-bit words, runs a sticky repetition-count health test and buffers words in a FIFO. Words are dispatched strictly round-robin to NUM_PORTS UART transmitters. It sits between the ring oscillator bank and the uart_transmitter instances.

Parameters:
NUM_PORTS, 1, number of transmitter ports served round-robin (1..16)
WORD_WIDTH, 8, bits per output word
FIFO_DEPTH, 4, word buffer depth (power of 2, >=2)
REP_LIMIT, 32, consecutive identical raw bits that trip the health test (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
raw_bit  in  1  raw entropy bit, sampled every clk edge
debias_en  in  1  1 = Von Neumann mode, 0 = raw pass-through mode
tx_ready  in  NUM_PORTS  per-port transmitter idle flag
tx_start  out  NUM_PORTS  per-port one-cycle start pulse
tx_word  out  WORD_WIDTH  word to transmit; shared by all ports
fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered
drop_count  out  16  words discarded because the FIFO was full; saturates at 0xFFFF
health_fail  out  1  sticky repetition-test failure

Behaviour:
- Reset: tx_start=0, tx_word=0, fifo_level=0, drop_count=0, health_fail=0. Also cleared: pair phase, bit_cnt, port pointer (port 0), run counter. The dispatcher returns to IDLE. Reset mid-word discards the partial word. Reset during a pulse drops tx_start the next cycle.
- De-bias, debias_en=1:
  - pair_phase toggles every cycle.
  - Phase 0 stores raw_bit as "first". Phase 1 compares it with the current raw_bit.
  - 10 emits 1, 01 emits 0; 00 and 11 emit nothing.
  - At most one new bit per two cycles.
- Raw mode, debias_en=0: raw_bit is emitted every cycle.
- debias_en change (registered compare with the previous value): discards the partial word, clears bit_cnt and resets pair_phase to 0 in that cycle. No bit is emitted that cycle.
- Assembler:
  - Each emitted bit is written to word[bit_cnt], LSB first.
  - When bit_cnt reaches WORD_WIDTH-1 and a bit is emitted, the completed word is pushed and bit_cnt wraps to 0.
  - No bit is reused between words.
- Push:
  - If the FIFO is full after this cycle's pop, the word is dropped and drop_count increments (saturating).
  - Push and pop in the same cycle are allowed; a pop frees space for a same-cycle push.
  - No push while health_fail=1.
- Health test:
  - The run counter counts consecutive equal raw_bit samples, starting at 1 after reset or on any change.
  - When it reaches REP_LIMIT, health_fail is set the following cycle. It stays set until reset.
  - Buffered words still drain while health_fail=1.
- Dispatcher FSM:
  - IDLE: if fifo_level!=0 and tx_ready[ptr]=1, register tx_word=head, pulse tx_start[ptr]=1 for exactly one cycle, pop, and go to GAP.
  - GAP: one idle cycle so the UART can drop tx_ready; then return to IDLE. ptr advances (wraps NUM_PORTS-1 -> 0) on each start.
  - A not-ready port is never skipped: words wait in order.
  - tx_word holds stable from the start pulse until the next start.
- Latency:
  - A word pushed at edge N raises fifo_level after N.
  - Earliest tx_start is asserted in the cycle after edge N+1 when the FIFO was empty and the dispatcher was IDLE.
  - Back-to-back words: one start every 2 cycles at most.
- At most one tx_start bit is high in any cycle.

Test Plan:
- NUM_PORTS=2, debias_en=1. Raw pairs 10,01,11,10,10,01,00,01,10,01 -> one tx_start[0] pulse, tx_word=0x4D, fifo_level back to 0.
- tx_ready=2'b01, generate 3 words A,B,C:
  - A goes to port0, then fifo_level=2 and the dispatcher waits.
  - Raise tx_ready[1]: B goes to port1, then C goes to port0.
  - No port is skipped and there are no double pulses.
- tx_ready=0, generate 6 words -> fifo_level=4, drop_count=2. Raise tx_ready: the first 4 words leave in push order.
- raw_bit held 1 for 32 cycles with debias_en=1:
  - health_fail=1 after cycle 32 and stays 1.
  - Words buffered before the trip still drain; no new pushes.
  - Reset clears health_fail.
- debias_en=0, raw 1,1,0,1,0,0,0,0 -> tx_word=0x0B. Toggling debias_en after 5 bits discards them, and the next word starts at bit 0.
- Reset asserted after 5 bits plus a pending word in the FIFO -> all outputs reset, fifo_level=0, the next word assembles from bit 0 and is sent to port 0.

Source files
------------

// File: rtl/hwrandom_pool.sv
// hwrandom_pool: conditions the raw ring-oscillator entropy bit, packs it into
// words, guards it with a repetition-count health test and hands the words
// round-robin to a bank of UART transmitters.
//
// Dispatcher states
//   state | meaning
//   IDLE  | waiting for a buffered word and tx_ready on the current port
//   GAP   | start just issued; one cycle for the UART to drop tx_ready
module hwrandom_pool #(
    parameter int NUM_PORTS  = 1,
    parameter int WORD_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          raw_bit,
    input  logic                          debias_en,
    input  logic [NUM_PORTS-1:0]          tx_ready,
    output logic [NUM_PORTS-1:0]          tx_start,
    output logic [WORD_WIDTH-1:0]         tx_word,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   drop_count,
    output logic                          health_fail
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int RW = $clog2(REP_LIMIT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    // bit source
    logic                  debias_q;
    logic                  mode_chg;
    logic                  pair_phase;
    logic                  first_bit;
    logic                  emit;
    logic                  emit_bit;

    // assembler
    logic [BW-1:0]         bit_cnt;
    logic [WORD_WIDTH-1:0] word_q;
    logic [WORD_WIDTH-1:0] word_full;
    logic                  word_done;

    // word buffer
    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         wr_ptr;
    logic [LW-1:0]         count;
    logic                  full_after_pop;
    logic                  push;
    logic                  drop;
    logic                  pop;

    // health test
    logic [RW-1:0]         run_cnt;
    logic                  last_bit;

    // dispatcher
    state_t                state;
    state_t                state_next;
    logic [PW-1:0]         port_ptr;
    logic                  start_fire;
    logic [NUM_PORTS-1:0]  start_vec;

    // Decide whether this cycle produces a conditioned bit, and which one.
    always_comb begin
        mode_chg = (debias_en != debias_q);
        emit     = 1'b0;
        emit_bit = raw_bit;
        if (!mode_chg) begin
            if (debias_en) begin
                if (pair_phase) begin
                    emit     = (first_bit != raw_bit);
                    emit_bit = first_bit;
                end
            end else begin
                emit = 1'b1;
            end
        end
    end

    // Track the mode and the Von Neumann pair state; a mode flip realigns pairs.
    always_ff @(posedge clk) begin
        if (reset) begin
            debias_q   <= debias_en;
            pair_phase <= 1'b0;
            first_bit  <= 1'b0;
        end else begin
            debias_q <= debias_en;
            if (mode_chg || !debias_en) begin
                pair_phase <= 1'b0;
            end else begin
                pair_phase <= ~pair_phase;
                if (!pair_phase) begin
                    first_bit <= raw_bit;
                end
            end
        end
    end

    // Merge the emitted bit into the word under construction.
    always_comb begin
        word_full          = word_q;
        word_full[bit_cnt] = emit_bit;
        word_done          = emit && (bit_cnt == BW'(WORD_WIDTH - 1));
    end

    // Advance the LSB-first bit position; a mode flip throws the partial word away.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
            word_q  <= '0;
        end else if (mode_chg) begin
            bit_cnt <= '0;
            word_q  <= '0;
        end else if (emit) begin
            if (word_done) begin
                bit_cnt <= '0;
                word_q  <= '0;
            end else begin
                bit_cnt <= bit_cnt + BW'(1);
                word_q  <= word_full;
            end
        end
    end

    // A pop in the same cycle frees a slot for the completed word.
    always_comb begin
        full_after_pop = (count == LW'(FIFO_DEPTH)) && !pop;
        push           = word_done && !health_fail && !full_after_pop;
        drop           = word_done && !health_fail && full_after_pop;
    end

    // Buffer storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= word_full;
        end
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Saturating count of words lost to a full buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    // Repetition-count test on the raw stream; the failure flag is sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt     <= '0;
            last_bit    <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            last_bit <= raw_bit;
            if ((run_cnt == '0) || (raw_bit != last_bit)) begin
                run_cnt <= RW'(1);
            end else if (run_cnt != RW'(REP_LIMIT)) begin
                run_cnt <= run_cnt + RW'(1);
            end
            if (run_cnt == RW'(REP_LIMIT)) begin
                health_fail <= 1'b1;
            end
        end
    end

    // Dispatcher state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dispatcher next state; the current port is never skipped.
    always_comb begin
        state_next = state;
        start_fire = 1'b0;
        start_vec  = '0;
        case (state)
            IDLE: begin
                if ((count != '0) && tx_ready[port_ptr]) begin
                    start_fire          = 1'b1;
                    start_vec[port_ptr] = 1'b1;
                    state_next          = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign pop = start_fire;

    // Registered start pulse, held word and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_start <= '0;
            tx_word  <= '0;
            port_ptr <= '0;
        end else begin
            tx_start <= start_vec;
            if (start_fire) begin
                tx_word  <= mem[rd_ptr];
                port_ptr <= (port_ptr == PW'(NUM_PORTS - 1)) ? '0 : port_ptr + PW'(1);
            end
        end
    end

    assign fifo_level = count;

endmodule

// File: tb/tb_hwrandom_pool.sv
// Testbench for hwrandom_pool: table-driven word checks, hand sequences for
// the round-robin, overflow, health, mode-change and reset cases, and a
// randomized phase against a queue-based reference model.
module tb_hwrandom_pool;

    localparam int NP = 2;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int RL = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          raw_bit;
    logic          debias_en;
    logic [NP-1:0] tx_ready;
    logic [NP-1:0] tx_start;
    logic [W-1:0]  tx_word;
    logic [2:0]    fifo_level;
    logic [15:0]   drop_count;
    logic          health_fail;

    always #5 clk = ~clk;

    hwrandom_pool #(
        .NUM_PORTS (NP),
        .WORD_WIDTH(W),
        .FIFO_DEPTH(D),
        .REP_LIMIT (RL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_bit    (raw_bit),
        .debias_en  (debias_en),
        .tx_ready   (tx_ready),
        .tx_start   (tx_start),
        .tx_word    (tx_word),
        .fifo_level (fifo_level),
        .drop_count (drop_count),
        .health_fail(health_fail)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    bit            m_deb_prev;
    bit            m_have_first;
    bit            m_first;
    bit            m_part[$];
    logic [W-1:0]  m_fifo[$];
    int            m_drop;
    bit            m_hf;
    int            m_run;
    bit            m_last;
    int            m_ptr;
    bit            m_cool;
    logic [NP-1:0] m_start;
    logic [W-1:0]  m_word;

    // observed starts
    logic [W-1:0]  sent_word[$];
    int            sent_port[$];
    logic [NP-1:0] prev_start;

    bit            cur_deb;
    logic [NP-1:0] cur_rdy;

    typedef struct {
        bit          deb;
        int          nbits;
        logic [31:0] seq;
        logic [7:0]  exp_word;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one call per clock edge with the inputs of that edge.
    function automatic void model_edge(bit r, bit deb, logic [NP-1:0] rdy, bit rst);
        bit           emit;
        bit           eb;
        logic [W-1:0] w;
        if (rst) begin
            m_deb_prev   = deb;
            m_have_first = 0;
            m_part.delete();
            m_fifo.delete();
            m_drop  = 0;
            m_hf    = 0;
            m_run   = 0;
            m_last  = 0;
            m_ptr   = 0;
            m_cool  = 0;
            m_start = '0;
            m_word  = '0;
            return;
        end
        m_start = '0;
        if (m_cool) begin
            m_cool = 0;
        end else if (m_fifo.size() > 0 && rdy[m_ptr]) begin
            m_word         = m_fifo.pop_front();
            m_start[m_ptr] = 1'b1;
            m_ptr          = (m_ptr + 1) % NP;
            m_cool         = 1;
        end
        emit = 0;
        eb   = 0;
        if (deb != m_deb_prev) begin
            m_part.delete();
            m_have_first = 0;
        end else if (deb) begin
            if (!m_have_first) begin
                m_first      = r;
                m_have_first = 1;
            end else begin
                m_have_first = 0;
                if (m_first != r) begin
                    emit = 1;
                    eb   = m_first;
                end
            end
        end else begin
            m_have_first = 0;
            emit = 1;
            eb   = r;
        end
        m_deb_prev = deb;
        if (emit) begin
            m_part.push_back(eb);
            if (m_part.size() == W) begin
                for (int i = 0; i < W; i++) w[i] = m_part[i];
                m_part.delete();
                if (!m_hf) begin
                    if (m_fifo.size() == D) begin
                        if (m_drop < 65535) m_drop++;
                    end else begin
                        m_fifo.push_back(w);
                    end
                end
            end
        end
        if (m_run == RL) m_hf = 1;
        if (m_run == 0 || r != m_last) m_run = 1;
        else if (m_run < RL) m_run++;
        m_last = r;
    endfunction

    task automatic step(input bit r, input bit deb, input logic [NP-1:0] rdy, input bit rst);
        int p;
        reset     = rst;
        raw_bit   = r;
        debias_en = deb;
        tx_ready  = rdy;
        @(posedge clk);
        #1;
        model_edge(r, deb, rdy, rst);
        check("model", {tx_start, tx_word, fifo_level, drop_count, health_fail},
              {m_start, m_word, 3'(m_fifo.size()), 16'(m_drop), m_hf});
        check("onehot_start", 32'($countones(tx_start) <= 1), 1);
        if (tx_start != '0) begin
            check("no_back_to_back", 32'(prev_start), 0);
            p = 0;
            for (int k = 0; k < NP; k++) if (tx_start[k]) p = k;
            sent_port.push_back(p);
            sent_word.push_back(tx_word);
        end
        prev_start = tx_start;
    endtask

    task automatic step_raw(input bit r);
        step(r, cur_deb, cur_rdy, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, cur_deb, cur_rdy, 1'b1);
        sent_word.delete();
        sent_port.delete();
        prev_start = '0;
    endtask

    task automatic send_db(input logic [7:0] w);
        for (int i = 0; i < W; i++) begin
            if (w[i]) begin step_raw(1'b1); step_raw(1'b0); end
            else      begin step_raw(1'b0); step_raw(1'b1); end
        end
    endtask

    task automatic idle_db(input int npairs);
        for (int k = 0; k < npairs; k++) begin
            step_raw(1'(k % 2));
            step_raw(1'(k % 2));
        end
    endtask

    task automatic send_raw(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) step_raw(w[i]);
    endtask

    task automatic check_sent(input string nm, input int idx, input int port, input logic [7:0] w);
        check({nm, "_present"}, 32'(sent_word.size() > idx), 1);
        if (sent_word.size() > idx) begin
            check({nm, "_port"}, sent_port[idx], port);
            check({nm, "_word"}, sent_word[idx], w);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 20, 32'h0009_8979, 8'h4D};
        vecs[1] = '{1'b0, 8,  32'h0000_000B, 8'h0B};
        vecs[2] = '{1'b0, 8,  32'h0000_00A5, 8'hA5};
        vecs[3] = '{1'b1, 16, 32'h0000_6996, 8'h96};
        vecs[4] = '{1'b0, 8,  32'h0000_00FF, 8'hFF};
        prev_start = '0;

        // reset state
        cur_deb = 1'b1;
        cur_rdy = 2'b11;
        do_reset();
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_word", tx_word, 0);
        check("rst_level", fifo_level, 0);
        check("rst_drop", drop_count, 0);
        check("rst_health", health_fail, 0);

        // table of single words with exact push/start latency
        for (int v = 0; v < 5; v++) begin
            cur_deb = vecs[v].deb;
            cur_rdy = 2'b11;
            do_reset();
            for (int i = 0; i < vecs[v].nbits; i++) step_raw(vecs[v].seq[i]);
            check("vec_level_pushed", fifo_level, 1);
            step_raw(1'b0);
            check("vec_start", tx_start, 2'b01);
            check("vec_word", tx_word, vecs[v].exp_word);
            check("vec_level_popped", fifo_level, 0);
        end

        // round robin with a port that is not ready
        cur_deb = 1'b1;
        cur_rdy = 2'b01;
        do_reset();
        send_db(8'hA1);
        send_db(8'hB2);
        send_db(8'hC3);
        idle_db(2);
        check("rr_level_wait", fifo_level, 2);
        check("rr_count_wait", sent_word.size(), 1);
        check_sent("rr_a", 0, 0, 8'hA1);
        cur_rdy = 2'b11;
        idle_db(4);
        check("rr_count_all", sent_word.size(), 3);
        check_sent("rr_b", 1, 1, 8'hB2);
        check_sent("rr_c", 2, 0, 8'hC3);
        check("rr_level_empty", fifo_level, 0);

        // overflow: six words into four slots
        cur_rdy = 2'b00;
        do_reset();
        for (int k = 0; k < 6; k++) send_db(8'(8'h10 + k * 8'h11));
        idle_db(1);
        check("ovf_level", fifo_level, 4);
        check("ovf_drop", drop_count, 2);
        check("ovf_none_sent", sent_word.size(), 0);
        cur_rdy = 2'b11;
        idle_db(6);
        check("ovf_count", sent_word.size(), 4);
        for (int k = 0; k < 4; k++) check_sent("ovf_order", k, k % 2, 8'(8'h10 + k * 8'h11));
        check("ovf_level_empty", fifo_level, 0);

        // repetition health test
        cur_rdy = 2'b00;
        do_reset();
        send_db(8'h81);
        send_db(8'hC5);
        for (int i = 0; i < 31; i++) step_raw(1'b1);
        check("hf_before_limit", health_fail, 0);
        for (int i = 0; i < 3; i++) step_raw(1'b1);
        check("hf_tripped", health_fail, 1);
        check("hf_level_kept", fifo_level, 2);
        send_db(8'h5A);
        check("hf_no_push", fifo_level, 2);
        check("hf_no_drop", drop_count, 0);
        cur_rdy = 2'b11;
        idle_db(4);
        check("hf_drained", sent_word.size(), 2);
        check_sent("hf_w0", 0, 0, 8'h81);
        check_sent("hf_w1", 1, 1, 8'hC5);
        check("hf_level_empty", fifo_level, 0);
        check("hf_sticky", health_fail, 1);
        do_reset();
        check("hf_cleared", health_fail, 0);

        // mode toggle discards a partial raw word
        cur_deb = 1'b0;
        cur_rdy = 2'b11;
        do_reset();
        send_raw(8'h15, 5);
        cur_deb = 1'b1;
        step_raw(1'b0);
        cur_deb = 1'b0;
        step_raw(1'b0);
        send_raw(8'h0B, 8);
        step_raw(1'b0);
        check("mode_count", sent_word.size(), 1);
        check_sent("mode_word", 0, 0, 8'h0B);

        // reset with a partial word and a pending buffered word
        cur_rdy = 2'b01;
        do_reset();
        send_raw(8'h21, 8);
        send_raw(8'h5A, 8);
        send_raw(8'h1F, 5);
        check("mid_level", fifo_level, 1);
        check_sent("mid_first", 0, 0, 8'h21);
        do_reset();
        check("mid_rst_start", tx_start, 0);
        check("mid_rst_word", tx_word, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_drop", drop_count, 0);
        send_raw(8'h3C, 8);
        step_raw(1'b0);
        check_sent("mid_after", 0, 0, 8'h3C);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(63) == 0) cur_deb = ~cur_deb;
            cur_rdy = NP'($urandom);
            step(1'($urandom), cur_deb, cur_rdy, $urandom_range(499) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
